// File: rtl/mod_addsub_pipe_if.sv
// rtl/mod_addsub_pipe_if.sv - handshake bundle for the pipelined modular add/sub
//
// Purpose: groups the request channel (in_*) and result channel (out_*) of
// mod_addsub_pipe. The master modport drives requests and accepts results; the
// slave modport is the datapath side.
//   in_valid/in_ready : request handshake
//   in_op             : 00 add, 01 sub, 10 double, 11 negate
//   in_a/in_b/in_p    : operands and per-transaction modulus
//   in_tag            : opaque sideband tag
//   out_valid/out_ready : result handshake
//   out_res/out_tag/out_err : result, its tag, operand-out-of-range flag

interface mod_addsub_pipe_if #(
  parameter int WIDTH = 256,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_p;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_p, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_p, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_err
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage pipelined modular add/sub/double/negate
//
// Purpose: computes (a op b) mod p with a per-transaction modulus, one
// operation per cycle, full valid/ready backpressure, 2-cycle latency.
// S1 forms the raw WIDTH+1 bit result; S2 applies the modular correction and
// drives the result channel.
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus     : request/result channels (mod_addsub_pipe_if.slave)

module mod_addsub_pipe #(
  parameter int WIDTH = 256,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  mod_addsub_pipe_if.slave bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DBL = 2'b10;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_raw_q, s1_raw_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_err_q, s1_err_d;
  logic             s1_azero_q, s1_azero_d;

  // Stage 2 registers (drive the result channel)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH:0]   a_ext, b_ext, p_ext, raw;
  logic [WIDTH:0]   s1_p_ext;
  logic [WIDTH-1:0] corr;

  // A stage refills when it is empty or its contents move on this cycle.
  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;

  assign bus.out_valid = s2_valid_q;
  assign bus.out_res   = s2_res_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_err   = s2_err_q;

  always_comb begin
    a_ext = {1'b0, bus.in_a};
    b_ext = {1'b0, bus.in_b};
    p_ext = {1'b0, bus.in_p};
    case (bus.in_op)
      OP_ADD:  raw = a_ext + b_ext;
      OP_SUB:  raw = a_ext - b_ext;   // top bit doubles as the borrow
      OP_DBL:  raw = a_ext + a_ext;
      default: raw = p_ext - a_ext;
    endcase

    s1_valid_d = s1_valid_q;
    s1_raw_d   = s1_raw_q;
    s1_p_d     = s1_p_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_err_d   = s1_err_q;
    s1_azero_d = s1_azero_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_load && bus.in_valid) begin
      s1_raw_d   = raw;
      s1_p_d     = bus.in_p;
      s1_op_d    = bus.in_op;
      s1_tag_d   = bus.in_tag;
      // b is only meaningful for add/sub (op[1] == 0)
      s1_err_d   = (bus.in_a >= bus.in_p) || (!bus.in_op[1] && (bus.in_b >= bus.in_p));
      // negate of zero gives raw == p, which must fold back to 0
      s1_azero_d = (bus.in_a == '0);
    end
  end

  always_comb begin
    s1_p_ext = {1'b0, s1_p_q};
    // Low WIDTH bits of the corrected sum are exact modulo 2^WIDTH, so the
    // correction is done on WIDTH bits once the decision is made.
    case (s1_op_q)
      OP_SUB:  corr = s1_raw_q[WIDTH] ? (s1_raw_q[WIDTH-1:0] + s1_p_q) : s1_raw_q[WIDTH-1:0];
      2'b11:   corr = s1_azero_q ? '0 : s1_raw_q[WIDTH-1:0];
      default: corr = (s1_raw_q >= s1_p_ext) ? (s1_raw_q[WIDTH-1:0] - s1_p_q)
                                             : s1_raw_q[WIDTH-1:0];
    endcase

    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load && s1_valid_q) begin
      s2_res_d = corr;
      s2_tag_d = s1_tag_q;
      s2_err_d = s1_err_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_p_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      s1_azero_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_raw_q   <= s1_raw_d;
      s1_p_q     <= s1_p_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      s1_azero_q <= s1_azero_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
    end
  end
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - self-checking bench for mod_addsub_pipe

module tb_mod_addsub_pipe;
  logic Clk;
  logic Reset_n;

  mod_addsub_pipe_if #(.WIDTH(8),   .TAG_W(4)) m8 ();
  mod_addsub_pipe_if #(.WIDTH(256), .TAG_W(4)) m256 ();

  mod_addsub_pipe #(.WIDTH(8),   .TAG_W(4)) u8   (.Clk(Clk), .Reset_n(Reset_n), .bus(m8));
  mod_addsub_pipe #(.WIDTH(256), .TAG_W(4)) u256 (.Clk(Clk), .Reset_n(Reset_n), .bus(m256));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [3:0] tag;
    logic       err;
    logic       chk;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [3:0] tag;
    logic [7:0] res;
    logic       err;
    logic       chk;
  } vec_t;

  exp_t exp_q[$];
  int   ret_cyc_q[$];
  logic mon_en = 1'b0;
  int   acc_cnt = 0;
  int   ret_cnt = 0;
  logic [7:0] cur_res;
  logic       cur_err;
  logic       cur_chk;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_res;
  logic [3:0] prev_tag;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model(input int op, input int a, input int b, input int p);
    case (op)
      0:       return (a + b) % p;
      1:       return (a - b + p) % p;
      2:       return (2 * a) % p;
      default: return (p - a) % p;
    endcase
  endfunction

  // Scoreboard on the 8-bit instance; sampled mid-cycle so both handshakes
  // reflect what the next rising edge will transfer.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_res_stable", 256'(m8.out_res), 256'(prev_res));
        check("stall_tag_stable", 256'(m8.out_tag), 256'(prev_tag));
      end
      stall_prev = m8.out_valid && !m8.out_ready;
      prev_res   = m8.out_res;
      prev_tag   = m8.out_tag;

      if (m8.out_valid && m8.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got tag %0d res %0d expected no result", m8.out_tag, m8.out_res);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_tag", 256'(m8.out_tag), 256'(e.tag));
          check("out_err", 256'(m8.out_err), 256'(e.err));
          if (e.chk) check("out_res", 256'(m8.out_res), 256'(e.res));
        end
        ret_cnt++;
        ret_cyc_q.push_back(cyc);
      end

      if (m8.in_valid && m8.in_ready) begin
        exp_t n;
        n.res = cur_res;
        n.tag = m8.in_tag;
        n.err = cur_err;
        n.chk = cur_chk;
        exp_q.push_back(n);
        acc_cnt++;
      end
    end
  end

  // Presents one op and returns #1 after the edge that accepted it; in_valid
  // stays high so calls chain back to back.
  task automatic push8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] p, input logic [3:0] tag,
                       input logic [7:0] er, input logic ee, input logic ec);
    logic ok;
    m8.in_op    = op;
    m8.in_a     = a;
    m8.in_b     = b;
    m8.in_p     = p;
    m8.in_tag   = tag;
    cur_res     = er;
    cur_err     = ee;
    cur_chk     = ec;
    m8.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (m8.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 for 50 cycles expected 1");
    end else begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      @(posedge Clk);
      #1;
    end
    check(name, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic op256(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] p, input logic [255:0] er, input string name);
    int lat;
    m256.in_op    = op;
    m256.in_a     = a;
    m256.in_b     = b;
    m256.in_p     = p;
    m256.in_tag   = 4'd5;
    m256.in_valid = 1'b1;
    check({name, "_in_ready"}, 256'(m256.in_ready), 256'(1));
    @(posedge Clk);
    #1;
    m256.in_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 10 && !m256.out_valid; k++) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 256'(lat), 256'(2));
    check({name, "_res"}, m256.out_res, er);
    check({name, "_err"}, 256'(m256.out_err), 256'(0));
  endtask

  vec_t vt[12];
  logic [255:0] big_p;

  initial begin
    int lat;
    int ret0;
    int acc0;

    vt[0]  = '{2'd0, 8'd20,  8'd7,   8'd23,  4'd3,  8'd4,  1'b0, 1'b1};
    vt[1]  = '{2'd0, 8'd5,   8'd6,   8'd23,  4'd1,  8'd11, 1'b0, 1'b1};
    vt[2]  = '{2'd1, 8'd3,   8'd10,  8'd23,  4'd2,  8'd16, 1'b0, 1'b1};
    vt[3]  = '{2'd1, 8'd10,  8'd10,  8'd23,  4'd4,  8'd0,  1'b0, 1'b1};
    vt[4]  = '{2'd3, 8'd0,   8'd9,   8'd23,  4'd5,  8'd0,  1'b0, 1'b1};
    vt[5]  = '{2'd3, 8'd1,   8'd0,   8'd23,  4'd6,  8'd22, 1'b0, 1'b1};
    vt[6]  = '{2'd2, 8'd12,  8'd0,   8'd23,  4'd7,  8'd1,  1'b0, 1'b1};
    vt[7]  = '{2'd2, 8'd3,   8'd200, 8'd23,  4'd8,  8'd6,  1'b0, 1'b1};
    vt[8]  = '{2'd0, 8'd23,  8'd0,   8'd23,  4'd9,  8'd0,  1'b1, 1'b0};
    vt[9]  = '{2'd1, 8'd1,   8'd30,  8'd23,  4'd10, 8'd0,  1'b1, 1'b0};
    vt[10] = '{2'd0, 8'd200, 8'd100, 8'd251, 4'd11, 8'd49, 1'b0, 1'b1};
    vt[11] = '{2'd1, 8'd0,   8'd250, 8'd251, 4'd12, 8'd1,  1'b0, 1'b1};

    m8.in_valid = 1'b0;  m8.in_op = '0;  m8.in_a = '0;  m8.in_b = '0;
    m8.in_p = '0;        m8.in_tag = '0; m8.out_ready = 1'b1;
    m256.in_valid = 1'b0; m256.in_op = '0; m256.in_a = '0; m256.in_b = '0;
    m256.in_p = '0;       m256.in_tag = '0; m256.out_ready = 1'b1;
    cur_res = '0; cur_err = 1'b0; cur_chk = 1'b0;

    // Reset state
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    check("rst_out_valid", 256'(m8.out_valid), 256'(0));
    check("rst_out_res",   256'(m8.out_res),   256'(0));
    check("rst_out_tag",   256'(m8.out_tag),   256'(0));
    check("rst_out_err",   256'(m8.out_err),   256'(0));
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_in_ready", 256'(m8.in_ready), 256'(1));
    mon_en = 1'b1;

    // Directed single-op vectors
    for (int i = 0; i < 12; i++) begin
      push8(vt[i].op, vt[i].a, vt[i].b, vt[i].p, vt[i].tag, vt[i].res, vt[i].err, vt[i].chk);
      m8.in_valid = 1'b0;
      lat = 1;
      for (int k = 0; k < 10 && !m8.out_valid; k++) begin
        @(posedge Clk);
        #1;
        lat++;
      end
      check("vec_latency", 256'(lat), 256'(2));
      wait_drain("vec_drain");
    end

    // Back-to-back stream of 8 mixed ops, alternating modulus
    ret0 = ret_cnt;
    ret_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      int p, a, b;
      p = (i % 2 == 1) ? 251 : 23;
      a = (i * 37 + 3) % p;
      b = (i * 53 + 11) % p;
      push8(2'(i % 4), 8'(a), 8'(b), 8'(p), 4'(i), 8'(model(i % 4, a, b, p)), 1'b0, 1'b1);
    end
    m8.in_valid = 1'b0;
    wait_drain("stream_drain");
    check("stream_count", 256'(ret_cnt - ret0), 256'(8));
    if (ret_cyc_q.size() == 8)
      check("stream_consecutive", 256'(ret_cyc_q[7] - ret_cyc_q[0]), 256'(7));

    // Backpressure: out_ready low for 5 cycles while streaming
    ret0 = ret_cnt;
    acc0 = acc_cnt;
    m8.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int a, b;
          a = (i * 5 + 2) % 23;
          b = (i * 9 + 4) % 23;
          push8(2'(i % 4), 8'(a), 8'(b), 8'd23, 4'(8 + i), 8'(model(i % 4, a, b, 23)), 1'b0, 1'b1);
        end
        m8.in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge Clk);
        #1;
        check("bp_accepts_when_full", 256'(acc_cnt - acc0), 256'(2));
        check("bp_in_ready_low", 256'(m8.in_ready), 256'(0));
        check("bp_out_valid_held", 256'(m8.out_valid), 256'(1));
        m8.out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_count", 256'(ret_cnt - ret0), 256'(6));

    // Full-width modulus p = 2^256 - 2^32 - 977
    big_p = {256{1'b1}} - 256'd4294968272;
    op256(2'd0, big_p - 256'd1, big_p - 256'd1, big_p, big_p - 256'd2, "w256_add");
    op256(2'd1, 256'd0, 256'd1, big_p, big_p - 256'd1, "w256_sub");

    // Reset with two ops in flight
    push8(2'd0, 8'd5, 8'd6, 8'd23, 4'd13, 8'd11, 1'b0, 1'b1);
    push8(2'd0, 8'd1, 8'd2, 8'd23, 4'd14, 8'd3,  1'b0, 1'b1);
    m8.in_valid = 1'b0;
    check("pre_rst_out_valid", 256'(m8.out_valid), 256'(1));
    Reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 256'(m8.out_valid), 256'(0));
    check("mid_rst_out_res",   256'(m8.out_res),   256'(0));
    check("mid_rst_out_tag",   256'(m8.out_tag),   256'(0));
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
      check("post_rst_no_output", 256'(m8.out_valid), 256'(0));
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor for the elliptic-curve datapath. It is the successor to the combinational mod-p add/sub.
- Supports four ops: add, sub, double, negate.
- Supports a per-transaction modulus, valid/ready flow control with full backpressure, a sideband tag, and an out-of-range flag.
- Sits between the point add/double sequencer and the field-element register file. Accepts one operation per cycle.

Parameters:
- WIDTH, 256, field element and modulus width in bits
- TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
- Clk  input  1  clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- in_op  input  2  00 add a+b, 01 sub a-b, 10 double 2a, 11 negate -a (b ignored for 10/11)
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_p  input  WIDTH  modulus p, odd, p > 2
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- out_res  output  WIDTH  (a op b) mod p
- out_tag  output  TAG_W  tag of this result
- out_err  output  1  a >= p, or b >= p for add/sub

Behaviour:
- Reset (async assert, sync release): stage valids = 0, out_valid = 0, out_res = 0, out_tag = 0, out_err = 0. in_ready is high one cycle after release.
- Transfer rules: in accepts when in_valid && in_ready. out completes when out_valid && out_ready.
- Once asserted, out_valid and its data stay stable until accepted.
- Pipeline: two register stages, S1 and S2. S2 drives the outputs.
- Latency is 2 cycles from acceptance to out_valid, with out_ready held high.
- Throughput is 1 operation per cycle.
- Advance conditions:
  - S2 loads when !S2.valid || out_ready.
  - S1 loads when !S1.valid || S2 loads.
  - in_ready = !S1.valid || !S2.valid || out_ready (combinational path out_ready -> in_ready is permitted).
- Full pipe with out_ready low: in_ready = 0, and no data changes. When out_ready rises, accept and retire happen in the same cycle.
- S1 computes, on WIDTH+1 bits:
  - raw = a+b (add), a-b (sub), a+a (double), p-a (negate).
  - Also latches p, op, tag, and err.
  - err = (a >= p) || (op[1]==0 && b >= p).
- S2 applies the correction:
  - add/double: res = (raw >= p) ? raw-p : raw.
  - sub: res = raw[WIDTH] ? raw+p : raw. The borrow bit decides; this is not a comparison against p.
  - negate: res = (a==0) ? 0 : raw.
  - Only the low WIDTH bits are output.
- Precondition: operands are < p. If violated, out_err = 1 and out_res is don't-care (must not be X). The pipeline does not stall or drop the operation.
- Ordering and tags: results retire in acceptance order, and each tag exits with its own result.
- Reset mid-operation: all in-flight operations are discarded and outputs return to reset values immediately. No partial result is emitted after release.
- The modulus may change every transaction; there is no cross-transaction state beyond the pipeline registers.

Test Plan:
- WIDTH=8, p=23, single op, out_ready=1:
  - add a=20 b=7 tag=3 -> after 2 cycles out_res=4, out_tag=3, out_err=0.
  - add a=5 b=6 -> 11.
- Sub and negate, p=23:
  - sub a=3 b=10 -> 16; sub a=10 b=10 -> 0.
  - negate a=0 -> 0; negate a=1 -> 22.
  - double a=12 -> 1.
- Back-to-back stream of 8 mixed ops, one per cycle, with distinct tags -> 8 results on consecutive cycles, in order, each matching a reference model.
- Backpressure: stream ops while holding out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - out_res and out_tag stay stable.
  - After release, all results arrive in order with none lost or duplicated.
- WIDTH=256, p = 2^256-2^32-977:
  - add a=p-1 b=p-1 -> p-2.
  - sub a=0 b=1 -> p-1.
  - out_err=0 in both cases.
- Error and reset:
  - add a=23 b=0 with p=23 -> out_err=1.
  - Assert Reset_n low with 2 ops in flight -> out_valid=0 immediately, and no output appears after release.
